// File: rtl/lcd_sync_tracker.sv
// ============================================================================
// Module   : lcd_sync_tracker
// Purpose  : Classifies LCD composite-sync edges into line/frame starts,
//            verifies lines per frame, and publishes pixel coordinates + DE.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module lcd_sync_tracker #(
   parameter int P_CW          = 19,
   parameter int P_FRAME_GAP   = 1000,
   parameter int P_TIMEOUT     = 100000,
   parameter int P_LINES       = 480,
   parameter int P_HACTIVE     = 640,
   parameter int P_LOCK_FRAMES = 2
) (
   input  logic       iw_clk,
   input  logic       iw_reset,
   input  logic       iw_sync,
   output logic       ow_frame_start,
   output logic       ow_line_start,
   output logic       ow_de,
   output logic [9:0] ow_x,
   output logic [9:0] ow_y,
   output logic       ow_locked,
   output logic [9:0] ow_lines_last
);

   localparam int GW      = (P_LOCK_FRAMES < 2) ? 1 : $clog2(P_LOCK_FRAMES + 1);
   localparam int HLAST_I = P_HACTIVE - 1;

   localparam logic [P_CW-1:0] C_FRAME_GAP = P_FRAME_GAP[P_CW-1:0];
   localparam logic [P_CW-1:0] C_TIMEOUT   = P_TIMEOUT[P_CW-1:0];
   localparam logic [P_CW-1:0] C_GAP_MAX   = '1;
   localparam logic [9:0]      C_LINES     = P_LINES[9:0];
   localparam logic [9:0]      C_HLAST     = HLAST_I[9:0];
   localparam logic [9:0]      C_SAT10     = 10'h3FF;
   localparam logic [GW-1:0]   C_LOCK      = P_LOCK_FRAMES[GW-1:0];

   typedef enum logic [1:0] {
      S_SEARCH = 2'd0,
      S_VERIFY = 2'd1,
      S_LOCKED = 2'd2
   } state_t;

   logic            sync1_q, sync2_q, dly_q;
   logic [P_CW-1:0] gap_q, gap_d;
   state_t          state_q, state_d;
   logic [GW-1:0]   good_q, good_d, w_good_inc;
   logic            run_q, run_d;
   logic [9:0]      x_q, x_d;
   logic [9:0]      y_q, y_d;
   logic [9:0]      lines_q, lines_d;
   logic            fs_q, ls_q, de_q, locked_q;
   logic            w_edge, w_frame, w_timeout;
   logic [9:0]      w_lines;

   assign w_edge     = sync2_q & ~dly_q;
   assign w_frame    = w_edge && (gap_q > C_FRAME_GAP);
   assign w_timeout  = (gap_q == C_TIMEOUT);
   assign w_lines    = (y_q == C_SAT10) ? y_q : y_q + 10'd1;
   assign w_good_inc = good_q + GW'(1);

   always_comb begin
      gap_d   = gap_q;
      y_d     = y_q;
      lines_d = lines_q;
      x_d     = x_q;
      run_d   = run_q;
      state_d = state_q;
      good_d  = good_q;

      if (w_edge) begin
         gap_d = '0;
      end else if (gap_q != C_GAP_MAX) begin
         gap_d = gap_q + P_CW'(1);
      end

      if (w_frame) begin
         y_d     = 10'd0;
         lines_d = w_lines;
      end else if (w_edge) begin
         y_d = w_lines;
      end

      // Any edge restarts the active run, even one arriving mid-line.
      if (w_edge) begin
         x_d   = 10'd0;
         run_d = 1'b1;
      end else if (run_q) begin
         if (x_q == C_HLAST) begin
            run_d = 1'b0;
         end else begin
            x_d = x_q + 10'd1;
         end
      end

      if (w_timeout) begin
         state_d = S_SEARCH;
         good_d  = '0;
      end else if (w_frame) begin
         case (state_q)
            S_SEARCH: begin
               state_d = S_VERIFY;
               good_d  = '0;
            end
            S_VERIFY: begin
               if (w_lines == C_LINES) begin
                  if (w_good_inc == C_LOCK) begin
                     state_d = S_LOCKED;
                     good_d  = '0;
                  end else begin
                     good_d = w_good_inc;
                  end
               end else begin
                  good_d = '0;
               end
            end
            S_LOCKED: begin
               if (w_lines != C_LINES) begin
                  state_d = S_VERIFY;
                  good_d  = '0;
               end
            end
            default: begin
               state_d = S_SEARCH;
               good_d  = '0;
            end
         endcase
      end
   end

   always_ff @(posedge iw_clk) begin
      if (iw_reset) begin
         sync1_q  <= 1'b0;
         sync2_q  <= 1'b0;
         dly_q    <= 1'b0;
         gap_q    <= '0;
         state_q  <= S_SEARCH;
         good_q   <= '0;
         run_q    <= 1'b0;
         x_q      <= 10'd0;
         y_q      <= 10'd0;
         lines_q  <= 10'd0;
         fs_q     <= 1'b0;
         ls_q     <= 1'b0;
         de_q     <= 1'b0;
         locked_q <= 1'b0;
      end else begin
         sync1_q  <= iw_sync;
         sync2_q  <= sync1_q;
         dly_q    <= sync2_q;
         gap_q    <= gap_d;
         state_q  <= state_d;
         good_q   <= good_d;
         run_q    <= run_d;
         x_q      <= x_d;
         y_q      <= y_d;
         lines_q  <= lines_d;
         fs_q     <= w_frame;
         ls_q     <= w_edge;
         de_q     <= run_d && (state_d == S_LOCKED);
         locked_q <= (state_d == S_LOCKED);
      end
   end

   assign ow_frame_start = fs_q;
   assign ow_line_start  = ls_q;
   assign ow_de          = de_q;
   assign ow_x           = x_q;
   assign ow_y           = y_q;
   assign ow_locked      = locked_q;
   assign ow_lines_last  = lines_q;

endmodule

`default_nettype wire

// File: doc/lcd_sync_tracker.md
# lcd_sync_tracker

Upstream front end of the HP54542C LCD-to-VGA converter. Samples the scope's LCD composite sync on the LCD pixel clock. Classifies each sync rising edge as a line start or, after a long idle gap, a frame start. Verifies the line count per frame and, once stable, publishes pixel coordinates and a data-enable that the VGA timing stage consumes.

## Interface
Parameters:
- P_CW, 19: gap-counter width; counter saturates at 2^P_CW-1.
- P_FRAME_GAP, 1000: a gap strictly greater than this (in clocks) marks a frame edge.
- P_TIMEOUT, 100000: gap reaching this value forces loss of lock. Must be < 2^P_CW.
- P_LINES, 480: lines per valid frame.
- P_HACTIVE, 640: active pixels per line.
- P_LOCK_FRAMES, 2: consecutive valid frames required to lock.

Ports:
- iw_clk, in, 1: LCD pixel clock; the only clock.
- iw_reset, in, 1: synchronous, active-high reset.
- iw_sync, in, 1: raw LCD composite sync; asynchronous to iw_clk.
- ow_frame_start, out, 1: one-cycle pulse on each frame edge.
- ow_line_start, out, 1: one-cycle pulse on every line edge, including frame edges.
- ow_de, out, 1: active-pixel enable; asserted only while LOCKED.
- ow_x, out, 10: pixel index within the current line.
- ow_y, out, 10: line index within the current frame.
- ow_locked, out, 1: high in LOCKED state.
- ow_lines_last, out, 10: line count of the last completed frame; saturates at 1023.

## Operation
- iw_sync passes through a two-flop synchronizer plus one delay flop. Edge = s2 & ~d.
- Gap counter:
  - On a non-edge cycle, increments, saturating at 2^P_CW-1.
  - On an edge cycle, the old value is compared, then the counter clears to 0.
- Edge classification: gap > P_FRAME_GAP means frame edge; otherwise line edge.
- Line edge: ow_line_start pulses; ow_y increments, saturating at 1023.
- Frame edge:
  - ow_frame_start and ow_line_start both pulse.
  - ow_lines_last <= ow_y+1, saturating at 1023.
  - ow_y <= 0.
- Pixel counting:
  - Every line edge sets ow_x=0 and starts a P_HACTIVE-cycle run: ow_x counts 0..P_HACTIVE-1, then holds at P_HACTIVE-1.
  - A new edge mid-run restarts the run at 0.
  - ow_de is high during the run only in LOCKED state.
- State machine: SEARCH, VERIFY, LOCKED, plus a good-frame counter.
  - SEARCH, on frame edge: go to VERIFY, good=0. The first frame edge is not scored.
  - VERIFY, on frame edge with line count == P_LINES: good+1. When good+1 == P_LOCK_FRAMES, go to LOCKED.
  - VERIFY, on frame edge with any other line count: good=0, stay in VERIFY.
  - LOCKED, on frame edge with line count != P_LINES: go to VERIFY, good=0.
  - Any state, when gap reaches P_TIMEOUT: go to SEARCH, good=0. This is evaluated every cycle; a timeout in the same cycle as an edge takes priority.
- ow_locked is registered from the next state. It changes in the same cycle as the ow_frame_start pulse that caused the transition.

## Timing
- Reset values: all outputs 0, state SEARCH, synchronizer flops 0, gap 0, good 0.
- If iw_sync is high at reset release, that high counts as a rising edge. It classifies as a line edge because the gap is near 0.
- Latency: clock edge E0 first samples iw_sync=1; the edge is detected at E1. ow_line_start/ow_frame_start go high after E2, for exactly one cycle.
- ow_x=0 and ow_y update in that same pulse cycle. ow_de, when LOCKED, goes high in that same cycle.
- Minimum detectable sync high/low width: 2 clocks.
- iw_reset asserted mid-frame: every output is 0 after the next clock edge.
- iw_reset dominates all other events.

## Test plan
- Reset with sync toggling: iw_reset held high for 50 clocks while iw_sync toggles every 5 clocks -> all outputs 0 throughout.
- Lock acquisition: frames of 480 lines, 800-clock line period, sync high 8 clocks, 36000-clock idle between frames -> ow_frame_start on every frame edge; ow_locked rises in the third ow_frame_start cycle; ow_lines_last = 480.
- Edge latency and pixels: while locked, check the iw_sync rise to ow_line_start latency (2 edges) -> ow_de high exactly 640 cycles with ow_x 0..639; ow_y increments 0..479.
- Bad frame: while locked, send one frame of 479 lines -> ow_locked falls with that frame's ow_frame_start; ow_lines_last = 479; relock after 2 further good frames.
- Timeout: while locked, hold iw_sync low for 100000 clocks -> ow_locked low and state SEARCH. The following frame edge does not lock; lock takes 3 frame edges again.
- Short line and reset: while locked, send a line edge 500 clocks after the previous one -> ow_x restarts at 0 and ow_de stays high. Then assert iw_reset mid-line -> all outputs 0 after one clock.
